// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: ALU op codes and FSM state type.
package div_seq_pkg;

    localparam logic [4:0] ALU_SIGNED_DIV   = 5'b01100;
    localparam logic [4:0] ALU_UNSIGNED_DIV = 5'b01101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_SIGNED_DIV) || (op == ALU_UNSIGNED_DIV);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        // When the divisor fits, the true difference is below 2^WIDTH, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = fits ? diff : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer returning {HI=remainder, LO=quotient}.
// Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses the iterative phase.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           alucontrol_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 annul_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem, quo, dvsr;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic               sign_q, sign_r;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] fixed;
    logic               accept, signed_op, zero_fast;
    logic [WIDTH-1:0]   mag_a, mag_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .q_in    (quo),
        .divisor (dvsr),
        .rem_out (rem_next),
        .q_out   (quo_next)
    );

    always_comb begin
        accept    = start_i && is_div_op(alucontrol_i) && !annul_i;
        signed_op = (alucontrol_i == ALU_SIGNED_DIV);
        mag_a     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
`ifdef DIV_ZERO_FAST_EN
        zero_fast = (b_i == '0);
`else
        zero_fast = 1'b0;
`endif
        fixed     = {(sign_r ? -rem : rem), (sign_q ? -quo : quo)};
    end

    // DONE delivers combinationally so a same-cycle annul can still suppress the result.
    always_comb begin
        ready_o  = (state == S_DONE) && !annul_i;
        stall_o  = ((state == S_IDLE) && accept) || (state == S_BUSY);
        result_o = ready_o ? fixed : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_q <= '0;
        end else if (annul_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (zero_fast) begin
                            rem    <= a_i;
                            quo    <= '1;
                            dvsr   <= '0;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            rem    <= '0;
                            quo    <= mag_a;
                            dvsr   <= mag_b;
                            sign_q <= signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            sign_r <= signed_op && a_i[WIDTH-1];
                            state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_q <= fixed;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: vector table plus annul/reset/ignore sequences.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [4:0] ALU_ADD_CODE = 5'b00010;

    logic           clk = 1'b0;
    logic           rst;
    logic [4:0]     alucontrol_i;
    logic           start_i;
    logic [W-1:0]   a_i, b_i;
    logic           annul_i;
    logic           stall_o;
    logic           ready_o;
    logic [2*W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alucontrol_i (alucontrol_i),
        .start_i      (start_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .annul_i      (annul_i),
        .stall_o      (stall_o),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == '0) return 1;
`endif
        return W + 1;
    endfunction

    // Starts a divide in cycle 0 and watches stall/ready until delivery (bounded).
    task automatic run_div(input string nm, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit poke);
        int cyc;
        int stall_bad;
        int extra;
        bit got;
        @(posedge clk); #1;
        start_i = 1'b1; alucontrol_i = op; a_i = a; b_i = b;
        @(negedge clk);
        chk({nm, "_stall_c0"}, 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0; a_i = ~a; b_i = b + 1;
        cyc = 0; got = 1'b0; stall_bad = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready_o) got = 1'b1;
            else if (!stall_o) stall_bad++;
            if (poke && cyc == 5) begin
                start_i = 1'b1; alucontrol_i = ALU_UNSIGNED_DIV; a_i = 123; b_i = 1;
            end
            if (poke && cyc == 6) start_i = 1'b0;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(exp_latency(b)));
        chk({nm, "_result"}, result_o, exp);
        chk({nm, "_stall_at_ready"}, 64'(stall_o), 64'd0);
        chk({nm, "_stall_gaps"}, 64'(stall_bad), 64'd0);
        @(negedge clk);
        chk({nm, "_ready_pulse"}, 64'(ready_o), 64'd0);
        chk({nm, "_held"}, result_o, exp);
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (ready_o || stall_o) extra++;
            end
            chk({nm, "_no_relatch"}, 64'(extra), 64'd0);
            chk({nm, "_held_late"}, result_o, exp);
        end
    endtask

    initial begin
        vecs[0] = '{"divu_100_7",  ALU_UNSIGNED_DIV, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[1] = '{"div_m7_2",    ALU_SIGNED_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[2] = '{"div_7_m2",    ALU_SIGNED_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[3] = '{"div_ovf",     ALU_SIGNED_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[4] = '{"divu_ovf",    ALU_UNSIGNED_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[5] = '{"divu_5_0",    ALU_UNSIGNED_DIV, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6] = '{"div_m100_m7", ALU_SIGNED_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
        vecs[7] = '{"divu_max_1",  ALU_UNSIGNED_DIV, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[8] = '{"divu_3_10",   ALU_UNSIGNED_DIV, 32'd3,        32'd10,       32'd3,        32'd0};
`ifdef DIV_ZERO_FAST_EN
        vecs[9] = '{"div_m20_0",   ALU_SIGNED_DIV,   32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, 32'hFFFFFFFF};
`else
        vecs[9] = '{"div_m20_0",   ALU_SIGNED_DIV,   32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, 32'd1};
`endif

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; alucontrol_i = '0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);

        foreach (vecs[i]) begin
            run_div(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0);
        end

        // Start pulsed mid-divide must not disturb the running operation.
        run_div("busy_poke", ALU_UNSIGNED_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);

        // Non-divide op in IDLE is ignored.
        @(posedge clk); #1;
        start_i = 1'b1; alucontrol_i = ALU_ADD_CODE; a_i = 77; b_i = 7;
        @(negedge clk);
        chk("nondiv_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("nondiv_idle", {62'd0, stall_o, ready_o}, 64'd0);
        chk("nondiv_held", result_o, {32'd2, 32'd14});

        // Annul together with start in IDLE: no start.
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; alucontrol_i = ALU_UNSIGNED_DIV; a_i = 50; b_i = 5;
        @(negedge clk);
        chk("annul_start_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        chk("annul_start_idle", {62'd0, stall_o, ready_o}, 64'd0);

        // Annul at cycle 10 of a DIVU.
        @(posedge clk); #1;
        start_i = 1'b1; alucontrol_i = ALU_UNSIGNED_DIV; a_i = 1000; b_i = 3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        chk("annul_c11_stall", 64'(stall_o), 64'd0);
        chk("annul_c11_result", result_o, {32'd2, 32'd14});
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (ready_o) seen++;
            end
            chk("annul_no_ready", 64'(seen), 64'd0);
        end
        run_div("after_annul", ALU_UNSIGNED_DIV, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

        // Annul in the DONE cycle suppresses delivery.
        @(posedge clk); #1;
        start_i = 1'b1; alucontrol_i = ALU_UNSIGNED_DIV; a_i = 100; b_i = 7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (W) @(posedge clk);
        #1 annul_i = 1'b1;
        @(negedge clk);
        chk("annul_done_ready", 64'(ready_o), 64'd0);
        chk("annul_done_result", result_o, {32'd0, 32'd3});
        @(posedge clk); #1;
        annul_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("annul_done_idle", {62'd0, stall_o, ready_o}, 64'd0);
        chk("annul_done_held", result_o, {32'd0, 32'd3});

        // Reset mid-divide.
        @(posedge clk); #1;
        start_i = 1'b1; alucontrol_i = ALU_SIGNED_DIV; a_i = 77; b_i = 7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_idle", {62'd0, stall_o, ready_o}, 64'd0);
        chk("midreset_result", result_o, 64'd0);
        run_div("after_reset", ALU_UNSIGNED_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
